// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master/slave pair: opcode values, frame
// widths and the 3-bit master state encoding.
package spi_pkg;

   localparam int unsigned FRAME_W_DEF = 10;
   localparam int unsigned DATA_W_DEF  = 8;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SELECT    = 3'd1;
   localparam logic [2:0] ST_SHIFT_CMD = 3'd2;
   localparam logic [2:0] ST_WAIT_RD   = 3'd3;
   localparam logic [2:0] ST_SHIFT_RD  = 3'd4;
   localparam logic [2:0] ST_DESELECT  = 3'd5;

   // True for the only opcode that expects data back on MISO.
   function automatic logic is_read_data(input logic [1:0] op);
      return op == CMD_RD_DATA;
   endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Parameterised shift register: parallel load, shifts left (MSB out,
// shift_in enters at the LSB). Load has priority over shift.
module spi_shift_reg #(
   parameter int unsigned W = 8
) (
   input  logic         CLK,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         shift,
   input  logic         shift_in,
   output logic [W-1:0] q
);

   // Register update: reset, load or one-bit left shift.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= load_data;
      end else if (shift) begin
         q <= {q[W-2:0], shift_in};
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI master for the 10-bit command / 8-bit read-data protocol.
// Optional feature: define SPI_MASTER_MISO_SYNC_EN to pass MISO through a
// 2-flop synchronizer; WAIT_RD then lasts READ_GAP+2 cycles.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned FRAME_W     = FRAME_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned READ_GAP    = 3,
   parameter int unsigned SS_HIGH_CYC = 2
) (
   input  logic               CLK,
   input  logic               rst_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [FRAME_W-1:0] cmd_data,
   output logic               rsp_valid,
   output logic [DATA_W-1:0]  rsp_data,
   output logic               SS_n,
   output logic               MOSI,
   input  logic               MISO
);

`ifdef SPI_MASTER_MISO_SYNC_EN
   localparam int unsigned WAIT_CYC = READ_GAP + 2;
`else
   localparam int unsigned WAIT_CYC = READ_GAP;
`endif

   localparam int unsigned CNT_MAX = FRAME_W + DATA_W + WAIT_CYC + SS_HIGH_CYC + 2;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   logic [2:0]         state;
   logic [CNT_W-1:0]   cnt;
   logic               ss_n_q;
   logic               mosi_q;
   logic               rsp_valid_q;
   logic [DATA_W-1:0]  rsp_data_q;

   logic [FRAME_W-1:0] tx_q;
   logic               tx_load;
   logic               tx_shift;
   logic [DATA_W-1:0]  rx_q;
   logic               rx_shift;
   logic               miso_s;
   logic               rd_op;
   logic               frame_sent;
   logic               unused_bits;

`ifdef SPI_MASTER_MISO_SYNC_EN
   logic [1:0] miso_sync;

   // Two-flop synchronizer for MISO arriving from a pad or foreign domain.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         miso_sync <= '0;
      end else begin
         miso_sync <= {miso_sync[0], MISO};
      end
   end

   assign miso_s = miso_sync[1];
`else
   assign miso_s = MISO;
`endif

   // The TX register rotates (MSB fed back into LSB), so after all FRAME_W
   // bits are sent it holds the original command again and the opcode can be
   // read from its top bits without a separate opcode latch.
   assign frame_sent = (cnt == CNT_W'(FRAME_W));
   assign rd_op      = is_read_data(tx_q[FRAME_W-1 -: 2]);

   // Shift-register controls derived from the current state.
   always_comb begin
      tx_load  = 1'b0;
      tx_shift = 1'b0;
      rx_shift = 1'b0;
      case (state)
         ST_IDLE:      tx_load  = cmd_valid;
         ST_SELECT:    tx_shift = 1'b1;
         ST_SHIFT_CMD: tx_shift = !frame_sent;
         ST_SHIFT_RD:  rx_shift = 1'b1;
         default:      ;
      endcase
   end

   spi_shift_reg #(.W(FRAME_W)) u_tx (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .load      (tx_load),
      .load_data (cmd_data),
      .shift     (tx_shift),
      .shift_in  (tx_q[FRAME_W-1]),
      .q         (tx_q)
   );

   spi_shift_reg #(.W(DATA_W)) u_rx (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .load      (1'b0),
      .load_data ('0),
      .shift     (rx_shift),
      .shift_in  (miso_s),
      .q         (rx_q)
   );

   // Transaction FSM: select, command shift-out, optional read, deselect.
   always_ff @(posedge CLK) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         ss_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  ss_n_q <= 1'b0;
                  state  <= ST_SELECT;
               end
            end
            ST_SELECT: begin
               mosi_q <= tx_q[FRAME_W-1];
               cnt    <= CNT_W'(1);
               state  <= ST_SHIFT_CMD;
            end
            ST_SHIFT_CMD: begin
               if (frame_sent) begin
                  cnt    <= '0;
                  mosi_q <= 1'b0;
                  if (rd_op) begin
                     state <= ST_WAIT_RD;
                  end else begin
                     ss_n_q <= 1'b1;
                     state  <= ST_DESELECT;
                  end
               end else begin
                  mosi_q <= tx_q[FRAME_W-1];
                  cnt    <= cnt + CNT_W'(1);
               end
            end
            ST_WAIT_RD: begin
               if (cnt == CNT_W'(WAIT_CYC - 1)) begin
                  cnt   <= '0;
                  state <= ST_SHIFT_RD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_SHIFT_RD: begin
               if (cnt == CNT_W'(DATA_W - 1)) begin
                  rsp_data_q  <= {rx_q[DATA_W-2:0], miso_s};
                  rsp_valid_q <= 1'b1;
                  ss_n_q      <= 1'b1;
                  cnt         <= '0;
                  state       <= ST_DESELECT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DESELECT: begin
               if (cnt == CNT_W'(SS_HIGH_CYC - 1)) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state  <= ST_IDLE;
               cnt    <= '0;
               ss_n_q <= 1'b1;
               mosi_q <= 1'b0;
            end
         endcase
      end
   end

   assign unused_bits = ^{tx_q[FRAME_W-3:0], rx_q[DATA_W-1]};

   assign cmd_ready = rst_n && (state == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign SS_n      = ss_n_q;
   assign MOSI      = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master with a behavioural SPI slave/RAM model.
// Builds with or without SPI_MASTER_MISO_SYNC_EN.
module tb_spi_master;
   import spi_pkg::*;

`ifdef SPI_MASTER_MISO_SYNC_EN
   localparam int unsigned RD_LAT  = 24;
   localparam logic [7:0]  RD_BYTE = 8'h5A;
`else
   localparam int unsigned RD_LAT  = 22;
   localparam logic [7:0]  RD_BYTE = 8'hC3;
`endif

   typedef struct {
      logic [7:0]  data;
      int unsigned cyc;
   } rsp_t;

   logic       CLK;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [9:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;

   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;

   rsp_t        exp_rsp[$];
   logic [9:0]  exp_frame[$];

   int unsigned s_cnt = 0;
   int unsigned s_n;
   logic [9:0]  s_frame = '0;
   logic [9:0]  s_f;
   logic [7:0]  s_addr = '0;
   logic [7:0]  s_mem [256];
   logic [7:0]  slave_rd_byte = '0;

   spi_master #(
      .FRAME_W     (10),
      .DATA_W      (8),
      .READ_GAP    (3),
      .SS_HIGH_CYC (2)
   ) dut (
      .CLK       (CLK),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .SS_n      (SS_n),
      .MOSI      (MOSI),
      .MISO      (MISO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name, input int unsigned act);
      total++;
      bad++;
      $display("FAIL %s: unexpected event, value 0x%0h (cyc %0d)", name, act, cyc);
   endtask

   // Response monitor: every rsp_valid pulse must match the oldest expectation.
   task automatic check_rsp();
      rsp_t e;
      if (exp_rsp.size() == 0) begin
         flag("rsp_unexpected", rsp_data);
      end else begin
         e = exp_rsp.pop_front();
         chk("rsp_data", rsp_data, e.data);
         chk("rsp_cycle", cyc, e.cyc);
         chk("rsp_ss_rise", SS_n, 1);
      end
   endtask

   always @(negedge CLK) begin
      if (rsp_valid === 1'b1) check_rsp();
   end

   // Frame monitor: each frame the slave model assembles is scored.
   task automatic check_frame(input logic [9:0] f);
      logic [9:0] e;
      if (exp_frame.size() == 0) begin
         flag("frame_unexpected", f);
      end else begin
         e = exp_frame.pop_front();
         chk("frame", f, e);
      end
   endtask

   // Slave model: samples MOSI one edge after the master drives it, and for
   // read-data frames drives MISO MSB first starting at slave edge 14.
   assign s_n = s_cnt + 1;
   assign s_f = (s_n >= 2 && s_n <= 11) ? {s_frame[8:0], MOSI} : s_frame;

   always @(posedge CLK) begin
      if (SS_n !== 1'b0) begin
         s_cnt <= 0;
         MISO  <= 1'b0;
      end else begin
         s_cnt   <= s_n;
         s_frame <= s_f;
         if (s_n == 11) begin
            check_frame(s_f);
            if (s_f[9:8] == CMD_WR_ADDR) s_addr <= s_f[7:0];
            if (s_f[9:8] == CMD_WR_DATA) s_mem[s_addr] <= s_f[7:0];
         end
         if (s_n >= 14 && s_n <= 21 && s_f[9:8] == CMD_RD_DATA)
            MISO <= slave_rd_byte[3'(21 - s_n)];
         else
            MISO <= 1'b0;
      end
   end

   task automatic wait_ready();
      int unsigned n = 0;
      while (cmd_ready !== 1'b1 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk("ready_timeout", cmd_ready, 1);
   endtask

   // Present one command, return the cycle stamp of the negedge after acceptance.
   task automatic issue(input logic [9:0] c, output int unsigned c0);
      @(negedge CLK);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_data  = c;
      @(negedge CLK);
      c0        = cyc;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      chk("accept_ss_fall", SS_n, 0);
   endtask

   task automatic wait_ss(input logic v, output int unsigned t);
      int unsigned n = 0;
      while (SS_n !== v && n < 100) begin
         @(negedge CLK);
         n++;
      end
      chk("ss_wait_timeout", SS_n, v);
      t = cyc;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0]  c;
      int unsigned c0, t1, t2;

      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_data  = '0;
      repeat (3) @(negedge CLK);
      chk("rst_ss_n", SS_n, 1);
      chk("rst_mosi", MOSI, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      rst_n = 1'b1;
      @(negedge CLK);
      chk("idle_cmd_ready", cmd_ready, 1);

      // Write address 0x0A5 with a per-cycle waveform check.
      c = 10'h0A5;
      exp_frame.push_back(c);
      issue(c, c0);
      chk("wr_mosi_e0", MOSI, 0);
      for (int k = 1; k <= 14; k++) begin
         @(negedge CLK);
         chk($sformatf("wr_ss_n_k%0d", k), SS_n, (k >= 11) ? 1 : 0);
         chk($sformatf("wr_mosi_k%0d", k), MOSI, (k <= 10) ? c[10-k] : 0);
         chk($sformatf("wr_ready_k%0d", k), cmd_ready, (k >= 13) ? 1 : 0);
      end

      // Back-to-back write address / write data with cmd_valid held.
      exp_frame.push_back(10'h0A5);
      exp_frame.push_back(10'h13C);
      @(negedge CLK);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_data  = 10'h0A5;
      wait_ss(1'b0, t1);
      cmd_data = 10'h13C;
      wait_ss(1'b1, t2);
      wait_ss(1'b0, t2);
      cmd_valid = 1'b0;
      cmd_data  = '0;
      chk("b2b_period", t2 - t1, 14);
      @(negedge CLK);
      wait_ready();
      chk("ram_write", s_mem[8'hA5], 8'h3C);

      // Read data: slave returns RD_BYTE.
      slave_rd_byte = RD_BYTE;
      exp_frame.push_back(10'h300);
      issue(10'h300, c0);
      exp_rsp.push_back('{RD_BYTE, c0 + RD_LAT});
      for (int k = 1; k <= int'(RD_LAT) + 3; k++) begin
         @(negedge CLK);
         if (k == 12 || k == int'(RD_LAT) - 1) begin
            chk($sformatf("rd_ss_low_k%0d", k), SS_n, 0);
            chk($sformatf("rd_mosi_k%0d", k), MOSI, 0);
            chk($sformatf("rd_ready_k%0d", k), cmd_ready, 0);
         end
         if (k == int'(RD_LAT) + 1) begin
            chk("rd_pulse_single", rsp_valid, 0);
            chk("rd_data_hold", rsp_data, RD_BYTE);
         end
      end

      // Command offered during WAIT_RD must wait for the first IDLE cycle.
      exp_frame.push_back(10'h300);
      exp_frame.push_back(10'h055);
      issue(10'h300, c0);
      exp_rsp.push_back('{RD_BYTE, c0 + RD_LAT});
      repeat (11) @(negedge CLK);
      cmd_valid = 1'b1;
      cmd_data  = 10'h055;
      @(negedge CLK);
      chk("busy_ready_low", cmd_ready, 0);
      chk("busy_ss_low", SS_n, 0);
      wait_ss(1'b1, t1);
      wait_ss(1'b0, t2);
      cmd_valid = 1'b0;
      cmd_data  = '0;
      chk("busy_accept_delay", t2 - c0, RD_LAT + 3);
      @(negedge CLK);
      wait_ready();
      chk("rsp_hold_after_write", rsp_data, RD_BYTE);

      // Reset in the middle of SHIFT_CMD, after four bits.
      c = 10'h2FF;
      issue(c, c0);
      repeat (4) @(negedge CLK);
      chk("abort_mosi_bit4", MOSI, c[6]);
      rst_n = 1'b0;
      @(negedge CLK);
      chk("abort_ss_n", SS_n, 1);
      chk("abort_mosi", MOSI, 0);
      chk("abort_cmd_ready", cmd_ready, 0);
      chk("abort_rsp_valid", rsp_valid, 0);
      chk("abort_rsp_data", rsp_data, 0);
      rst_n = 1'b1;
      @(negedge CLK);
      chk("abort_ready_after", cmd_ready, 1);
      repeat (30) @(negedge CLK);

      // Recovery write after the abort.
      exp_frame.push_back(10'h17E);
      issue(10'h17E, c0);
      repeat (14) @(negedge CLK);
      chk("recover_ready", cmd_ready, 1);

      chk("rsp_queue_empty", exp_rsp.size(), 0);
      chk("frame_queue_empty", exp_frame.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI master for the 10-bit command / 8-bit read-data protocol spoken by the team's SPI slave and single-port RAM subsystem.
- Accepts one 10-bit command word per transaction from a local controller and drives SS_n/MOSI.
- For read-data commands (cmd[9:8]=2'b11), waits a fixed turnaround, samples 8 bits on MISO and returns them on a response port.
- Single clock domain: CLK is shared with the slave; both ends act on posedge.

Parameters:
- FRAME_W, 10, command frame width (2-bit opcode + 8-bit payload).
- DATA_W, 8, read-data width returned on MISO.
- READ_GAP, 3, CLK cycles spent in WAIT_RD between the last command bit and the first MISO sample edge; must be ≥1.
- SS_HIGH_CYC, 2, minimum CLK cycles SS_n is held high between transactions; must be ≥1.

Ports:
- CLK  in  1  clock; all logic posedge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command word available.
- cmd_ready  out  1  master idle; a command is accepted on a cycle with cmd_valid && cmd_ready.
- cmd_data  in  FRAME_W  command word, sent MSB first.
- rsp_valid  out  1  one-cycle pulse: rsp_data valid.
- rsp_data  out  DATA_W  read data, MSB received first; holds its value until the next read completes.
- SS_n  out  1  slave select, active low, registered.
- MOSI  out  1  serial data to slave, registered.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset (rst_n=0 at posedge): SS_n=1, MOSI=0, cmd_ready=0 during reset then 1 in IDLE, rsp_valid=0, rsp_data=0, state IDLE, counters cleared. Reset mid-transaction aborts immediately; no rsp_valid is produced.
- States: IDLE, SELECT, SHIFT_CMD, WAIT_RD, SHIFT_RD, DESELECT.
- IDLE: cmd_ready=1. On accept at edge E0: latch cmd_data into the shift register, SS_n<=0, go to SELECT.
- SELECT: lasts one cycle. This covers the slave's IDLE→CHK_CMD transition. At E1: MOSI<=cmd[9], bit counter<=1, go to SHIFT_CMD.
- SHIFT_CMD: at edges E2..E10, drive cmd[8]..cmd[0], one bit per edge. MOSI holds cmd[0] until E11. The slave samples bit k one edge after it is driven.
- At E11:
  - If opcode==2'b11, go to WAIT_RD with MOSI held at 0.
  - Otherwise SS_n<=1, MOSI<=0, go to DESELECT.
- WAIT_RD: SS_n stays 0; count READ_GAP cycles, then go to SHIFT_RD.
- SHIFT_RD: sample MISO on DATA_W consecutive edges and shift left into the receive register.
- On the edge of the 8th sample, in the same cycle:
  - rsp_data<=assembled byte (including that sample);
  - rsp_valid<=1 for one cycle;
  - SS_n<=1;
  - go to DESELECT.
- DESELECT: SS_n=1 for SS_HIGH_CYC cycles, then IDLE. cmd_ready is 0 in every state except IDLE.
- Latency:
  - Write-type commands (00/01/10): accept to SS_n rise = 11 cycles; back-to-back issue period = 12+SS_HIGH_CYC.
  - Read-data: accept to rsp_valid = 11+READ_GAP+DATA_W cycles.
- cmd_valid while busy: ignored, not queued. The controller must hold the command until cmd_ready.
- A stale/undriven MISO (slave has no data) simply returns whatever is sampled; there is no error detection.

Optional Feature:
- Macro SPI_MASTER_MISO_SYNC_EN.
- Defined: MISO passes through a 2-flop synchronizer before sampling. WAIT_RD duration becomes READ_GAP+2, so read latency increases by 2 cycles. Used when MISO arrives from a pad or another domain.
- Undefined: MISO is sampled directly; latency as above.

Decomposition:
- Package spi_pkg:
  - opcode constants CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11;
  - FRAME_W/DATA_W defaults;
  - master state encoding (3-bit, shared style with the slave FSM).
- One sub-module: spi_shift_reg, a parameterised width shift register with load, shift-out MSB and shift-in LSB. It is instantiated once for TX (FRAME_W) and once for RX (DATA_W).
- The FSM and counters stay in spi_master.

Test Plan:
- Reset mid-SHIFT_CMD (after 4 bits) → SS_n=1, MOSI=0, cmd_ready=1 after release, no rsp_valid.
- Write address cmd 10'h0A5 → SS_n falls at E0; MOSI bits 0,0,1,0,1,0,0,1,0,1 on E1..E10; SS_n high at E11 for 2 cycles; cmd_ready high at E13.
- Back-to-back 10'h0A5 then 10'h13C with cmd_valid held → second SS_n fall exactly 14 cycles after the first; slave model RAM receives address 0xA5 then data 0x3C.
- Read data 10'h300, slave model returns 0xC3 → rsp_valid single pulse at cycle 22, rsp_data=8'hC3, SS_n rises the same edge.
- cmd_valid asserted during WAIT_RD with 10'h055 → not accepted; accepted only at the first IDLE cycle, frame sent intact.
- SPI_MASTER_MISO_SYNC_EN defined, read returning 0x5A → rsp_valid at cycle 24, rsp_data=8'h5A.
